// File: rtl/frame_wr_packer.sv
// Packs IN_DW-wide video samples into FIFO_DW-wide write-FIFO words,
// framed by vs_in rising edges, with a per-frame FIFO clear pulse.
module frame_wr_packer #(
  parameter int IN_DW      = 8,
  parameter int FIFO_DW    = 16,
  parameter int CLR_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               vs_in,
  input  logic               de_in,
  input  logic [IN_DW-1:0]   din,
  input  logic               wrfifo_full,
  output logic               wrfifo_clr,
  output logic               wrfifo_wren,
  output logic [FIFO_DW-1:0] wrfifo_din,
  output logic               frame_done,
  output logic [23:0]        word_cnt,
  output logic               ovf
);

  localparam int RATIO = FIFO_DW / IN_DW;
  localparam int LW    = (RATIO > 1) ? $clog2(RATIO) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CLR,
    ACTIVE
  } state_e;

  state_e             state_q;
  logic               vs_q;
  logic               clr_q;
  logic [7:0]         clr_cnt_q;
  logic [FIFO_DW-1:0] pack_q;
  logic [FIFO_DW-1:0] pack_d;
  logic [LW-1:0]      lane_q;
  logic               pend_q;
  logic [FIFO_DW-1:0] word_q;
  logic               done_q;
  logic               close_q;
  logic               flush_q;
  logic               go_clr_q;
  logic [23:0]        cnt_q;
  logic               ovf_q;

  logic vs_rise;
  logic last_lane;

  assign vs_rise   = vs_in & ~vs_q;
  assign last_lane = (lane_q == LW'(RATIO - 1));

  always_comb begin
    pack_d = pack_q;
    for (int i = 0; i < RATIO; i++) begin
      if (lane_q == LW'(i)) pack_d[i*IN_DW +: IN_DW] = din;
    end
  end

  // A pending word is offered for one cycle; full at that moment drops it.
  assign wrfifo_wren = pend_q & ~wrfifo_full;
  assign wrfifo_din  = word_q;
  assign wrfifo_clr  = clr_q;
  assign frame_done  = done_q;
  assign word_cnt    = cnt_q;
  assign ovf         = ovf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      vs_q      <= 1'b1;
      clr_q     <= 1'b0;
      clr_cnt_q <= '0;
      pack_q    <= '0;
      lane_q    <= '0;
      pend_q    <= 1'b0;
      word_q    <= '0;
      done_q    <= 1'b0;
      close_q   <= 1'b0;
      flush_q   <= 1'b0;
      go_clr_q  <= 1'b0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      vs_q   <= vs_in;
      done_q <= 1'b0;
      pend_q <= 1'b0;
      if (pend_q) begin
        if (wrfifo_full) begin
          ovf_q <= 1'b1;
        end else if (cnt_q != 24'hFFFFFF) begin
          cnt_q <= cnt_q + 24'd1;
        end
      end
      unique case (state_q)
        IDLE: begin
          if (vs_rise && enable) begin
            state_q   <= CLR;
            clr_q     <= 1'b1;
            clr_cnt_q <= 8'(CLR_CYCLES - 1);
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            pack_q    <= '0;
            lane_q    <= '0;
          end
        end
        CLR: begin
          if (clr_cnt_q == 8'd0) begin
            state_q <= ACTIVE;
            clr_q   <= 1'b0;
          end else begin
            clr_cnt_q <= clr_cnt_q - 8'd1;
          end
        end
        ACTIVE: begin
          if (close_q) begin
            // Counters stay visible through frame_done before a new clear.
            if (done_q) begin
              close_q <= 1'b0;
              if (go_clr_q) begin
                state_q   <= CLR;
                clr_q     <= 1'b1;
                clr_cnt_q <= 8'(CLR_CYCLES - 1);
                cnt_q     <= '0;
                ovf_q     <= 1'b0;
                pack_q    <= '0;
                lane_q    <= '0;
              end else begin
                state_q <= IDLE;
              end
            end else if (flush_q) begin
              flush_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end else if (vs_rise) begin
            close_q  <= 1'b1;
            go_clr_q <= enable;
            if (lane_q != '0) begin
              pend_q  <= 1'b1;
              word_q  <= pack_q;
              pack_q  <= '0;
              lane_q  <= '0;
              flush_q <= 1'b1;
            end else begin
              done_q <= 1'b1;
            end
          end else if (de_in) begin
            if (last_lane) begin
              pend_q <= 1'b1;
              word_q <= pack_d;
              pack_q <= '0;
              lane_q <= '0;
            end else begin
              pack_q <= pack_d;
              lane_q <= lane_q + LW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_wr_packer.sv
// Directed and randomized frames checked against a byte-to-word
// reference model built from the frame contents.
module tb_frame_wr_packer;

  localparam int IN_DW      = 8;
  localparam int FIFO_DW    = 16;
  localparam int CLR_CYCLES = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        vs_in = 1'b0;
  logic        de_in = 1'b0;
  logic [7:0]  din = '0;
  logic        wrfifo_full = 1'b0;
  logic        wrfifo_clr;
  logic        wrfifo_wren;
  logic [15:0] wrfifo_din;
  logic        frame_done;
  logic [23:0] word_cnt;
  logic        ovf;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int clr_n = 0;
  int done_n = 0;
  int last_wren_cyc = 0;
  int done_cyc = 0;
  logic [15:0] got[$];
  logic [23:0] done_cnt = '0;
  logic        done_ovf = 1'b0;

  frame_wr_packer #(
    .IN_DW(IN_DW),
    .FIFO_DW(FIFO_DW),
    .CLR_CYCLES(CLR_CYCLES)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .vs_in(vs_in),
    .de_in(de_in),
    .din(din),
    .wrfifo_full(wrfifo_full),
    .wrfifo_clr(wrfifo_clr),
    .wrfifo_wren(wrfifo_wren),
    .wrfifo_din(wrfifo_din),
    .frame_done(frame_done),
    .word_cnt(word_cnt),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wrfifo_wren) begin
      got.push_back(wrfifo_din);
      last_wren_cyc = cyc;
    end
    if (wrfifo_clr) clr_n = clr_n + 1;
    if (frame_done) begin
      done_n   = done_n + 1;
      done_cyc = cyc;
      done_cnt = word_cnt;
      done_ovf = ovf;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input logic [7:0] bytes[$], input int drop,
                           input string nm);
    logic [15:0] exp[$];
    logic [15:0] w;
    logic        eovf;
    int          n;
    eovf = 1'b0;
    n = bytes.size();
    for (int i = 0; i < n; i += 2) begin
      w = {(i + 1 < n) ? bytes[i+1] : 8'h00, bytes[i]};
      if (i / 2 == drop) eovf = 1'b1;
      else exp.push_back(w);
    end
    got.delete();
    clr_n  = 0;
    done_n = 0;
    vs_in = 1'b0;
    de_in = 1'b0;
    step(2);
    vs_in  = 1'b1;
    enable = 1'b1;
    step(1);
    chk({nm, "_clr_on"}, 32'(wrfifo_clr), 32'd1);
    chk({nm, "_cnt_clr"}, 32'(word_cnt), 32'd0);
    chk({nm, "_ovf_clr"}, 32'(ovf), 32'd0);
    enable = 1'($urandom);
    vs_in  = 1'b0;
    for (int i = 0; i < CLR_CYCLES; i++) begin
      de_in = 1'($urandom);
      din   = 8'($urandom);
      step(1);
    end
    de_in = 1'b0;
    for (int i = 0; i < n; i++) begin
      step($urandom_range(0, 2));
      de_in = 1'b1;
      din   = bytes[i];
      step(1);
      de_in = 1'b0;
      if ((i % 2 == 1) && (i / 2 == drop)) begin
        wrfifo_full = 1'b1;
        step(1);
        wrfifo_full = 1'b0;
      end
    end
    step($urandom_range(0, 2));
    vs_in  = 1'b1;
    enable = 1'b0;
    de_in  = 1'($urandom);
    din    = 8'($urandom);
    step(1);
    de_in = 1'b0;
    step(6);
    chk({nm, "_clr_len"}, 32'(clr_n), 32'(CLR_CYCLES));
    chk({nm, "_nwords"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s_word%0d", nm, i), 32'(got[i]), 32'(exp[i]));
    chk({nm, "_done_n"}, 32'(done_n), 32'd1);
    chk({nm, "_done_cnt"}, 32'(done_cnt), 32'(exp.size()));
    chk({nm, "_done_ovf"}, 32'(done_ovf), 32'(eovf));
    if (n % 2 == 1)
      chk({nm, "_done_lat"}, 32'(done_cyc - last_wren_cyc), 32'd1);
    chk({nm, "_cnt_hold"}, 32'(word_cnt), 32'(exp.size()));
    chk({nm, "_ovf_hold"}, 32'(ovf), 32'(eovf));
  endtask

  initial begin
    logic [7:0] q[$];
    int nb;
    int dr;

    vs_in = 1'b1;
    step(2);
    chk("rst_outs", 32'({wrfifo_clr, wrfifo_wren, frame_done, ovf, wrfifo_din}),
        32'd0);
    chk("rst_cnt", 32'(word_cnt), 32'd0);
    reset_n = 1'b1;
    enable  = 1'b1;
    step(6);
    chk("rst_vs_high_no_clr", 32'(clr_n), 32'd0);

    q = {8'h11, 8'h22, 8'h33, 8'h44};
    run_frame(q, -1, "pack4");
    q = {8'h11, 8'h22, 8'h55};
    run_frame(q, -1, "flush3");
    q = {8'h01, 8'h02, 8'h03, 8'h04};
    run_frame(q, 1, "full");
    q = {8'h66};
    run_frame(q, -1, "ovf_clear");
    q.delete();
    run_frame(q, -1, "empty");

    for (int f = 0; f < 8; f++) begin
      q.delete();
      nb = $urandom_range(0, 9);
      for (int i = 0; i < nb; i++) q.push_back(8'($urandom));
      dr = -1;
      if (nb / 2 > 0 && $urandom_range(0, 1) == 1)
        dr = $urandom_range(0, nb / 2 - 1);
      run_frame(q, dr, $sformatf("rnd%0d", f));
    end

    got.delete();
    done_n = 0;
    vs_in = 1'b0;
    step(2);
    vs_in  = 1'b1;
    enable = 1'b1;
    step(1);
    vs_in = 1'b0;
    step(CLR_CYCLES);
    de_in = 1'b1;
    din   = 8'hAA;
    step(1);
    de_in = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_outs",
        32'({wrfifo_clr, wrfifo_wren, frame_done, ovf, wrfifo_din}), 32'd0);
    chk("midrst_cnt", 32'(word_cnt), 32'd0);
    step(2);
    reset_n = 1'b1;
    step(10);
    chk("midrst_no_wren", 32'(got.size()), 32'd0);
    chk("midrst_no_done", 32'(done_n), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
